ign_channel_sched: RTL and testbench
====================================

# ign_channel_sched

Per-cylinder ignition output scheduler sitting directly downstream of the hwag angle generator. It consumes the synchronised 24-bit angle count and the hwag_start sync flag. It drives one coil output: charge begins at a programmed charge angle and the spark fires at a programmed fire angle. An optional dwell-limit timer forces an early fire. Angle pairs are double-buffered so that software writes never corrupt a charge already in progress.

## Interface
- AW, 24, angle width (matches acnt2 width)
- TW, 24, dwell-limit timer width in clk cycles
- clk  in  1  system clock; the only clock
- rst  in  1  reset; one clock, reset is synchronous and active-low
- hwag_start  in  1  angle sync valid from hwag; low = angle invalid
- acnt  in  AW  current crank angle count (steps by ≤1 per cycle, wraps at max to 0)
- ch_ena  in  1  channel enable
- cfg_we  in  1  single-cycle write strobe for angle pair
- cfg_chrg  in  AW  charge-start angle
- cfg_fire  in  AW  fire angle
- max_dwell  in  TW  dwell limit in cycles; 0 = no limit
- ign_out  out  1  coil drive, high = charging
- fire_p  out  1  one-cycle pulse on each spark (normal or forced)
- dwell_ovf_p  out  1  one-cycle pulse when dwell limit forced the fire
- abort_p  out  1  one-cycle pulse when a charge is dropped by loss of sync
- pend  out  1  written angle pair not yet applied

## Operation
- Shadow pair (sh_chrg, sh_fire) is the pair used for compares. Pending pair (pd_chrg, pd_fire) is written by cfg_we, which sets pend.
- Apply rule: the pending pair is copied to the shadow pair and pend clears on any cycle where state ≠ CHARGE. A write during CHARGE is held until CHARGE exits. cfg_we in the apply cycle is captured and stays pending (last write wins).
- States:
  - IDLE: taken when hwag_start=0 or ch_ena=0. Goes to ARMED when both are high.
  - ARMED: goes to CHARGE when acnt==sh_chrg and ch_ena=1.
  - CHARGE: ign_out=1 and the dwell counter runs.
    - acnt==sh_fire → ARMED, with fire_p.
    - Dwell count reaches max_dwell (max_dwell≠0) → LOCKOUT, with fire_p and dwell_ovf_p.
  - LOCKOUT: ign_out=0. Goes to ARMED on acnt==sh_fire, which prevents a recharge in the same cycle.
- hwag_start=0 in any state → IDLE next cycle, ign_out=0. abort_p is pulsed only if the state was CHARGE; there is no fire_p.
- ch_ena=0 in CHARGE does not end the charge; the channel fires at the fire angle, then enters IDLE.
- sh_chrg==sh_fire: the ARMED→CHARGE compare has priority and the CHARGE exit compare is evaluated from the next cycle, so the charge lasts one full revolution. Software must avoid this; the verification engineer checks this defined behaviour.
- Dwell counter: TW bits, cleared on CHARGE entry, increments each cycle in CHARGE, saturates at all-ones.
- Compares are exact equality on AW bits. Wrap of acnt needs no special handling.

## Timing
- Reset (rst=0 at clk edge): state IDLE, ign_out=0, all pulses 0, pend=0, shadow and pending registers 0, dwell counter 0.
- All outputs are registered. ign_out rises on the cycle after the edge where acnt==sh_chrg is sampled, and falls on the cycle after acnt==sh_fire is sampled.
- fire_p is asserted in the same cycle ign_out falls. dwell_ovf_p is asserted in the same cycle as its fire_p.
- Dwell: with max_dwell=N, ign_out is high for exactly N cycles.
- Apply latency: pend goes high the cycle after cfg_we and clears one cycle later if state ≠ CHARGE.
- Simultaneous events in CHARGE: the fire-angle match and the dwell limit in the same cycle count as a normal fire (→ARMED, no dwell_ovf_p). Loss of sync takes priority over both.

## Configuration
- IGN_DWELL_LIMIT_EN defined: dwell counter, LOCKOUT state and dwell_ovf_p are present as described.
- Not defined: no dwell counter. max_dwell is ignored, LOCKOUT is unreachable, dwell_ovf_p is tied to 0, and CHARGE exits only on the fire angle or loss of sync.

## Test plan
- Reset, then hwag_start=1, ch_ena=1, cfg 100/160, acnt ramps 0..359 → ign_out high for acnt samples 100..159 (60 steps), one fire_p, pend cleared before acnt=100.
- Same setup, write 200/260 while acnt=130 (in CHARGE) → pend=1 until fire at 160, then applied; next charge at 200.
- IGN_DWELL_LIMIT_EN, max_dwell=25, acnt steps every 4 cycles, cfg 100/160 → ign_out high 25 cycles, fire_p+dwell_ovf_p together, no recharge until acnt passes 160.
- Drop hwag_start while acnt=120 in CHARGE → ign_out=0 next cycle, abort_p=1, fire_p=0, state IDLE. Restore hwag_start → ARMED.
- Wrap: cfg 350/10, acnt wraps 359→0 → ign_out high for samples 350..359 and 0..9, single fire_p at 10.
- rst=0 asserted mid-CHARGE → next cycle ign_out=0, pend=0, no pulses.

Source files
------------

// File: rtl/ign_channel_sched.sv
// rtl/ign_channel_sched.sv - per-cylinder ignition charge/fire scheduler with double-buffered angle pair
// Optional dwell-limit timer and LOCKOUT state are built when IGN_DWELL_LIMIT_EN is defined.
module ign_channel_sched #(
    parameter int AW = 24,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hwag_start,
    input  logic [AW-1:0] acnt,
    input  logic          ch_ena,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_chrg,
    input  logic [AW-1:0] cfg_fire,
    input  logic [TW-1:0] max_dwell,
    output logic          ign_out,
    output logic          fire_p,
    output logic          dwell_ovf_p,
    output logic          abort_p,
    output logic          pend
);
    typedef enum logic [1:0] {IDLE, ARMED, CHARGE, LOCKOUT} state_t;

    state_t        state;
    logic [AW-1:0] sh_chrg;
    logic [AW-1:0] sh_fire;
    logic [AW-1:0] pd_chrg;
    logic [AW-1:0] pd_fire;
    logic          at_chrg;
    logic          at_fire;

    assign at_chrg = (acnt == sh_chrg);
    assign at_fire = (acnt == sh_fire);

`ifdef IGN_DWELL_LIMIT_EN
    localparam logic [TW:0]   WIDE_ONE = 1;
    localparam logic [TW-1:0] CNT_ONE  = 1;

    logic [TW-1:0] dwell_cnt;
    logic          dwell_hit;

    // Fires on the cycle that completes max_dwell charging cycles; >= keeps a
    // mid-charge reduction of max_dwell from being skipped over.
    assign dwell_hit = (max_dwell != '0) &&
                       (({1'b0, dwell_cnt} + WIDE_ONE) >= {1'b0, max_dwell});

    always_ff @(posedge clk) begin
        if (!rst || state != CHARGE) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != '1) begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
        end
    end
`else
    logic unused_max_dwell;
    assign unused_max_dwell = ^max_dwell;
    assign dwell_ovf_p      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ign_out <= 1'b0;
            fire_p  <= 1'b0;
            abort_p <= 1'b0;
            pend    <= 1'b0;
            sh_chrg <= '0;
            sh_fire <= '0;
            pd_chrg <= '0;
            pd_fire <= '0;
`ifdef IGN_DWELL_LIMIT_EN
            dwell_ovf_p <= 1'b0;
`endif
        end else begin
            fire_p  <= 1'b0;
            abort_p <= 1'b0;
`ifdef IGN_DWELL_LIMIT_EN
            dwell_ovf_p <= 1'b0;
`endif
            // Shadow update is held off while charging so the active pair stays intact.
            if (pend && state != CHARGE) begin
                sh_chrg <= pd_chrg;
                sh_fire <= pd_fire;
                pend    <= 1'b0;
            end
            if (cfg_we) begin
                pd_chrg <= cfg_chrg;
                pd_fire <= cfg_fire;
                pend    <= 1'b1;
            end

            if (!hwag_start) begin
                state   <= IDLE;
                ign_out <= 1'b0;
                abort_p <= (state == CHARGE);
            end else begin
                case (state)
                    IDLE: begin
                        if (ch_ena) state <= ARMED;
                    end
                    ARMED: begin
                        if (!ch_ena) begin
                            state <= IDLE;
                        end else if (at_chrg) begin
                            state   <= CHARGE;
                            ign_out <= 1'b1;
                        end
                    end
                    CHARGE: begin
                        if (at_fire) begin
                            state   <= ch_ena ? ARMED : IDLE;
                            ign_out <= 1'b0;
                            fire_p  <= 1'b1;
                        end
`ifdef IGN_DWELL_LIMIT_EN
                        else if (dwell_hit) begin
                            state       <= LOCKOUT;
                            ign_out     <= 1'b0;
                            fire_p      <= 1'b1;
                            dwell_ovf_p <= 1'b1;
                        end
`endif
                    end
                    LOCKOUT: begin
                        // Leaving only at the fire angle blocks a recharge within the same window.
                        if (at_fire) state <= ch_ena ? ARMED : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ign_channel_sched.sv
// tb/tb_ign_channel_sched.sv - self-checking bench for ign_channel_sched
// Honours IGN_DWELL_LIMIT_EN to select the expected dwell-limit behaviour.
module tb_ign_channel_sched;
`ifdef IGN_DWELL_LIMIT_EN
    localparam bit DW_EN = 1'b1;
`else
    localparam bit DW_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        hwag_start;
    logic [23:0] acnt;
    logic        ch_ena;
    logic        cfg_we;
    logic [23:0] cfg_chrg;
    logic [23:0] cfg_fire;
    logic [23:0] max_dwell;
    logic        ign_out;
    logic        fire_p;
    logic        dwell_ovf_p;
    logic        abort_p;
    logic        pend;

    ign_channel_sched #(.AW(24), .TW(24)) dut (
        .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt), .ch_ena(ch_ena),
        .cfg_we(cfg_we), .cfg_chrg(cfg_chrg), .cfg_fire(cfg_fire), .max_dwell(max_dwell),
        .ign_out(ign_out), .fire_p(fire_p), .dwell_ovf_p(dwell_ovf_p),
        .abort_p(abort_p), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int n_ign, n_fire, n_ovf, n_abort;

    // Reference model: channel phase flags, angle pairs and a plain charged-cycle count.
    bit          m_armed, m_chg, m_lock, m_pend;
    logic [23:0] m_sc, m_sf, m_pc, m_pf;
    int          m_dwell;
    bit          e_ign, e_fire, e_ovf, e_abort;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [23:0] oc, of;
        e_fire = 0; e_ovf = 0; e_abort = 0;
        if (!rst) begin
            m_armed = 0; m_chg = 0; m_lock = 0; m_pend = 0; m_dwell = 0;
            m_sc = 0; m_sf = 0; m_pc = 0; m_pf = 0; e_ign = 0;
            return;
        end
        oc = m_sc;
        of = m_sf;
        if (m_pend && !m_chg) begin
            m_sc = m_pc; m_sf = m_pf; m_pend = 0;
        end
        if (cfg_we) begin
            m_pc = cfg_chrg; m_pf = cfg_fire; m_pend = 1;
        end
        if (!hwag_start) begin
            e_abort = m_chg;
            m_armed = 0; m_chg = 0; m_lock = 0; e_ign = 0;
        end else if (m_chg) begin
            m_dwell++;
            if (acnt == of) begin
                m_chg = 0; m_armed = ch_ena; e_ign = 0; e_fire = 1;
            end else if (DW_EN && max_dwell != 0 && m_dwell >= int'(max_dwell)) begin
                m_chg = 0; m_lock = 1; e_ign = 0; e_fire = 1; e_ovf = 1;
            end
        end else if (m_lock) begin
            if (acnt == of) begin
                m_lock = 0; m_armed = ch_ena;
            end
        end else if (m_armed) begin
            if (!ch_ena) m_armed = 0;
            else if (acnt == oc) begin
                m_armed = 0; m_chg = 1; m_dwell = 0; e_ign = 1;
            end
        end else if (ch_ena) begin
            m_armed = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ign_out", int'(ign_out), int'(e_ign));
        check("fire_p", int'(fire_p), int'(e_fire));
        check("dwell_ovf_p", int'(dwell_ovf_p), int'(e_ovf));
        check("abort_p", int'(abort_p), int'(e_abort));
        check("pend", int'(pend), int'(m_pend));
        n_ign   += int'(ign_out);
        n_fire  += int'(fire_p);
        n_ovf   += int'(dwell_ovf_p);
        n_abort += int'(abort_p);
    endtask

    task automatic zero_counts();
        n_ign = 0; n_fire = 0; n_ovf = 0; n_abort = 0;
    endtask

    task automatic ramp(input int from, input int steps, input int every);
        for (int s = 0; s < steps; s++) begin
            acnt = 24'((from + s) % 360);
            for (int k = 0; k < every; k++) begin
                tick();
                cfg_we = 1'b0;
            end
        end
    endtask

    task automatic write_cfg(input int c, input int f);
        cfg_chrg = 24'(c);
        cfg_fire = 24'(f);
        cfg_we   = 1'b1;
    endtask

    initial begin
        rst = 1'b0; hwag_start = 1'b0; ch_ena = 1'b0; cfg_we = 1'b0;
        acnt = '0; cfg_chrg = '0; cfg_fire = '0; max_dwell = '0;
        zero_counts();

        // reset state
        tick();
        tick();
        check("reset_ign", int'(ign_out), 0);
        check("reset_pend", int'(pend), 0);

        // basic 100/160 window
        rst = 1'b1; hwag_start = 1'b1; ch_ena = 1'b1;
        write_cfg(100, 160);
        zero_counts();
        ramp(0, 100, 1);
        check("pend_before_100", int'(pend), 0);
        ramp(100, 260, 1);
        check("basic_ign_cycles", n_ign, 60);
        check("basic_fires", n_fire, 1);

        // write during CHARGE is held until the fire
        zero_counts();
        ramp(0, 130, 1);
        write_cfg(200, 260);
        ramp(130, 20, 1);
        check("pend_held_in_charge", int'(pend), 1);
        ramp(150, 20, 1);
        check("pend_applied_after_fire", int'(pend), 0);
        ramp(170, 190, 1);
        check("deferred_ign_cycles", n_ign, 120);
        check("deferred_fires", n_fire, 2);

        // dwell limit, acnt stepping every 4 cycles
        write_cfg(100, 160);
        max_dwell = 24'd25;
        zero_counts();
        ramp(0, 360, 4);
        check("dwell_ign_cycles", n_ign, DW_EN ? 25 : 240);
        check("dwell_fires", n_fire, 1);
        check("dwell_ovf_count", n_ovf, DW_EN ? 1 : 0);
        max_dwell = '0;

        // loss of sync mid-charge
        zero_counts();
        ramp(0, 121, 1);
        hwag_start = 1'b0;
        tick();
        check("abort_ign", int'(ign_out), 0);
        check("abort_pulse", int'(abort_p), 1);
        check("abort_no_fire", int'(fire_p), 0);
        hwag_start = 1'b1;
        ramp(121, 239, 1);
        check("abort_total_fires", n_fire, 0);
        check("abort_total_aborts", n_abort, 1);

        // window across the wrap
        write_cfg(350, 10);
        zero_counts();
        ramp(300, 90, 1);
        check("wrap_ign_cycles", n_ign, 20);
        check("wrap_fires", n_fire, 1);

        // reset mid-charge with a write pending
        ramp(330, 23, 1);
        write_cfg(5, 50);
        ramp(353, 3, 1);
        check("pend_before_rst", int'(pend), 1);
        rst = 1'b0;
        tick();
        check("rst_ign", int'(ign_out), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_fire", int'(fire_p), 0);
        rst = 1'b1;

        // equal charge/fire angles (both 0 after reset): one full revolution of charge
        zero_counts();
        ramp(356, 370, 1);
        check("equal_ign_cycles", n_ign, 360);
        check("equal_fires", n_fire, 1);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) != 0) acnt = 24'((int'(acnt) + 1) % 360);
            cfg_we = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                cfg_chrg = 24'($urandom_range(0, 359));
                cfg_fire = ($urandom_range(0, 9) == 0) ? cfg_chrg : 24'($urandom_range(0, 359));
                cfg_we   = 1'b1;
            end
            hwag_start = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 149) == 0) ch_ena = ~ch_ena;
            if ($urandom_range(0, 499) == 0)
                max_dwell = ($urandom_range(0, 2) == 0) ? 24'd0 : 24'($urandom_range(10, 200));
            rst = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
